ex_mem_stage: RTL and testbench

//  EX->MEM pipeline boundary directly downstream of the ALU. Captures alu_result/alu_status with

---
 rtl/ex_mem_stage.sv | 153 +++++++++++++++
 tb/tb_ex_mem_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with a 2-entry skid buffer, zero-flag branch resolution and
// optional overflow trap (enabled by defining EX_MEM_OVF_TRAP_EN).
module ex_mem_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned STATUS_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic [STATUS_W-1:0]   ex_alu_status,
    input  logic [DATA_W-1:0]     ex_pc,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic [3:0]            ex_ctrl,
    input  logic                  ex_ovf_trap,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [DATA_W-1:0]     mem_alu_result,
    output logic [STATUS_W-1:0]   mem_alu_status,
    output logic [DATA_W-1:0]     mem_store_data,
    output logic [REG_ADDR_W-1:0] mem_rd_addr,
    output logic [2:0]            mem_ctrl,
    output logic                  branch_taken,
    output logic                  exc_valid,
    output logic [DATA_W-1:0]     exc_epc
);

    localparam int unsigned ZERO_BIT = 7;
    localparam int unsigned OVF_BIT  = 6;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic [STATUS_W-1:0]   status;
        logic [DATA_W-1:0]     store;
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            ctrl;
    } entry_t;

    state_e state_q, state_d;
    entry_t head_q, head_d, skid_q, skid_d, in_entry;
    logic   mem_valid_q, mem_valid_d;
    logic   ex_ready_q, ex_ready_d;
    logic   branch_taken_q, branch_taken_d;
    logic   accept, drain, kill;

    assign accept = ex_valid && ex_ready_q;
    assign drain  = mem_valid_q && mem_ready;

`ifdef EX_MEM_OVF_TRAP_EN
    logic              exc_valid_q, exc_valid_d;
    logic [DATA_W-1:0] exc_epc_q, exc_epc_d;

    assign kill = ex_ovf_trap && ex_alu_status[OVF_BIT];

    always_comb begin
        exc_valid_d = accept && !flush && kill;
        exc_epc_d   = exc_valid_d ? ex_pc : exc_epc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exc_valid_q <= 1'b0;
            exc_epc_q   <= '0;
        end else begin
            exc_valid_q <= exc_valid_d;
            exc_epc_q   <= exc_epc_d;
        end
    end

    assign exc_valid = exc_valid_q;
    assign exc_epc   = exc_epc_q;
`else
    logic unused_trap_inputs;

    assign kill               = 1'b0;
    assign unused_trap_inputs = ^{ex_ovf_trap, ex_pc};
    assign exc_valid          = 1'b0;
    assign exc_epc            = '0;
`endif

    // A killed beat still flows to MEM, but with its side-effect controls cleared.
    assign in_entry = '{result: ex_alu_result, status: ex_alu_status, store: ex_store_data,
                        rd: ex_rd_addr, ctrl: kill ? 3'b000 : ex_ctrl[3:1]};

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (!flush) begin
            unique case (state_q)
                EMPTY: if (accept) begin
                    head_d  = in_entry;
                    state_d = ONE;
                end
                ONE: begin
                    if (accept && drain) begin
                        head_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = FULL;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: if (drain) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end else begin
            state_d = EMPTY;
        end
        // Ready is registered from the next occupancy so it never depends on mem_ready.
        mem_valid_d    = (state_d != EMPTY);
        ex_ready_d     = (state_d != FULL);
        branch_taken_d = accept && !flush && ex_ctrl[0] && ex_alu_status[ZERO_BIT] && !kill;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= EMPTY;
            head_q         <= '0;
            skid_q         <= '0;
            mem_valid_q    <= 1'b0;
            ex_ready_q     <= 1'b0;
            branch_taken_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            skid_q         <= skid_d;
            mem_valid_q    <= mem_valid_d;
            ex_ready_q     <= ex_ready_d;
            branch_taken_q <= branch_taken_d;
        end
    end

    assign ex_ready       = ex_ready_q;
    assign mem_valid      = mem_valid_q;
    assign mem_alu_result = head_q.result;
    assign mem_alu_status = head_q.status;
    assign mem_store_data = head_q.store;
    assign mem_rd_addr    = head_q.rd;
    assign mem_ctrl       = head_q.ctrl;
    assign branch_taken   = branch_taken_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed-vector bench for ex_mem_stage: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ex_alu_result = '0;
    logic [7:0]  ex_alu_status = '0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_store_data = '0;
    logic [4:0]  ex_rd_addr = '0;
    logic [3:0]  ex_ctrl = '0;
    logic        ex_ovf_trap = 1'b0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_alu_result;
    logic [7:0]  mem_alu_status;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd_addr;
    logic [2:0]  mem_ctrl;
    logic        branch_taken;
    logic        exc_valid;
    logic [31:0] exc_epc;

    ex_mem_stage #(.DATA_W(32), .REG_ADDR_W(5), .STATUS_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_alu_status(ex_alu_status),
        .ex_pc(ex_pc), .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr),
        .ex_ctrl(ex_ctrl), .ex_ovf_trap(ex_ovf_trap),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_alu_result(mem_alu_result), .mem_alu_status(mem_alu_status),
        .mem_store_data(mem_store_data), .mem_rd_addr(mem_rd_addr),
        .mem_ctrl(mem_ctrl), .branch_taken(branch_taken),
        .exc_valid(exc_valid), .exc_epc(exc_epc)
    );

    always #5 clk = ~clk;

`ifdef EX_MEM_OVF_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] result;
        logic [7:0]  status;
        logic [31:0] store;
        logic [4:0]  rd;
        logic [2:0]  ctrl;
    } beat_t;

    int unsigned passed = 0;
    int unsigned total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the stage is a FIFO of depth 2 whose ready flag reflects
    // the occupancy left after each edge.
    beat_t       mq[$];
    logic        m_ready = 1'b0;
    logic        m_bt = 1'b0;
    logic        m_exc = 1'b0;
    logic [31:0] m_epc = '0;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_ready = 1'b0;
            m_bt    = 1'b0;
            m_exc   = 1'b0;
            m_epc   = '0;
        end else begin
            logic acc, drn, kill;
            acc   = ex_valid && m_ready;
            drn   = (mq.size() > 0) && mem_ready;
            m_bt  = 1'b0;
            m_exc = 1'b0;
            if (flush) begin
                mq.delete();
                m_ready = 1'b1;
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) begin
                    beat_t b;
                    kill     = TRAP_EN && ex_ovf_trap && ex_alu_status[6];
                    b.result = ex_alu_result;
                    b.status = ex_alu_status;
                    b.store  = ex_store_data;
                    b.rd     = ex_rd_addr;
                    b.ctrl   = kill ? 3'b000 : ex_ctrl[3:1];
                    mq.push_back(b);
                    m_bt = ex_ctrl[0] && ex_alu_status[7] && !kill;
                    if (kill) begin
                        m_exc = 1'b1;
                        m_epc = ex_pc;
                    end
                end
                m_ready = (mq.size() < 2);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("ex_ready", {31'd0, ex_ready}, {31'd0, m_ready});
        check("mem_valid", {31'd0, mem_valid}, {31'd0, mq.size() > 0});
        check("branch_taken", {31'd0, branch_taken}, {31'd0, m_bt});
        check("exc_valid", {31'd0, exc_valid}, {31'd0, m_exc});
        check("exc_epc", exc_epc, m_epc);
        if (mq.size() > 0) begin
            check("mem_alu_result", mem_alu_result, mq[0].result);
            check("mem_alu_status", {24'd0, mem_alu_status}, {24'd0, mq[0].status});
            check("mem_store_data", mem_store_data, mq[0].store);
            check("mem_rd_addr", {27'd0, mem_rd_addr}, {27'd0, mq[0].rd});
            check("mem_ctrl", {29'd0, mem_ctrl}, {29'd0, mq[0].ctrl});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [7:0] st,
                         input logic [31:0] pc, input logic [3:0] ctrl, input logic trap);
        ex_valid      = v;
        ex_alu_result = res;
        ex_alu_status = st;
        ex_pc         = pc;
        ex_store_data = res ^ 32'hA5A5_0000;
        ex_rd_addr    = res[4:0] + 5'd1;
        ex_ctrl       = ctrl;
        ex_ovf_trap   = trap;
    endtask

    initial begin
        tick();
        tick();
        check("reset_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("reset_ex_ready", {31'd0, ex_ready}, 32'd0);
        check("reset_result", mem_alu_result, 32'd0);
        check("reset_ctrl", {29'd0, mem_ctrl}, 32'd0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", {31'd0, ex_ready}, 32'd1);

        // 1: three back-to-back beats with MEM always ready
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'd5 + 32'(i), 8'h00, 32'h100 + 32'(4 * i), 4'b1000, 1'b0);
            tick();
            check("t1_valid", {31'd0, mem_valid}, 32'd1);
            check("t1_result", mem_alu_result, 32'd5 + 32'(i));
        end
        drive(1'b0, '0, '0, '0, '0, 1'b0);
        tick();
        check("t1_drained", {31'd0, mem_valid}, 32'd0);

        // 2: backpressure fills the skid buffer; the third beat must wait
        mem_ready = 1'b0;
        drive(1'b1, 32'h11, 8'h00, 32'h200, 4'b0100, 1'b0);
        tick();
        drive(1'b1, 32'h22, 8'h00, 32'h204, 4'b0010, 1'b0);
        tick();
        check("t2_not_ready", {31'd0, ex_ready}, 32'd0);
        drive(1'b1, 32'h33, 8'h00, 32'h208, 4'b1000, 1'b0);
        tick();
        check("t2_head_held", mem_alu_result, 32'h11);
        drive(1'b0, '0, '0, '0, '0, 1'b0);
        mem_ready = 1'b1;
        tick();
        check("t2_second", mem_alu_result, 32'h22);
        check("t2_second_ctrl", {29'd0, mem_ctrl}, 32'b001);
        tick();
        check("t2_empty", {31'd0, mem_valid}, 32'd0);

        // 3: zero-flag branch pulses once; non-zero branch does not
        drive(1'b1, 32'h0, 8'h80, 32'h300, 4'b0001, 1'b0);
        tick();
        check("t3_taken", {31'd0, branch_taken}, 32'd1);
        drive(1'b0, '0, '0, '0, '0, 1'b0);
        tick();
        check("t3_pulse_end", {31'd0, branch_taken}, 32'd0);
        drive(1'b1, 32'h4, 8'h00, 32'h304, 4'b0001, 1'b0);
        tick();
        check("t3_not_taken", {31'd0, branch_taken}, 32'd0);

        // 4: signed overflow with and without the trap attribute
        drive(1'b1, 32'h8000_0000, 8'h50, 32'h0040_0010, 4'b1000, 1'b1);
        tick();
        check("t4_ctrl", {29'd0, mem_ctrl}, TRAP_EN ? 32'b000 : 32'b100);
        check("t4_exc", {31'd0, exc_valid}, {31'd0, TRAP_EN});
        check("t4_epc", exc_epc, TRAP_EN ? 32'h0040_0010 : 32'h0);
        drive(1'b1, 32'h8000_0000, 8'h50, 32'h0040_0020, 4'b1000, 1'b0);
        tick();
        check("t4_ctrl_kept", {29'd0, mem_ctrl}, 32'b100);
        check("t4_no_exc", {31'd0, exc_valid}, 32'd0);
        check("t4_epc_held", exc_epc, TRAP_EN ? 32'h0040_0010 : 32'h0);

        // 5: flush a full buffer while a trapping branch beat is presented
        mem_ready = 1'b0;
        drive(1'b1, 32'h51, 8'h00, 32'h500, 4'b1000, 1'b0);
        tick();
        drive(1'b1, 32'h52, 8'h00, 32'h504, 4'b1000, 1'b0);
        tick();
        check("t5_full", {31'd0, ex_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'h0, 8'hC0, 32'h508, 4'b0001, 1'b1);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0, 1'b0);
        check("t5_valid", {31'd0, mem_valid}, 32'd0);
        check("t5_ready", {31'd0, ex_ready}, 32'd1);
        check("t5_no_bt", {31'd0, branch_taken}, 32'd0);
        check("t5_no_exc", {31'd0, exc_valid}, 32'd0);
        tick();

        // 6: asynchronous reset with a beat in flight and another being offered
        drive(1'b1, 32'h61, 8'h80, 32'h600, 4'b1001, 1'b0);
        tick();
        check("t6_bt_before", {31'd0, branch_taken}, 32'd1);
        drive(1'b1, 32'h62, 8'h80, 32'h604, 4'b1001, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t6_valid_zero", {31'd0, mem_valid}, 32'd0);
        check("t6_bt_zero", {31'd0, branch_taken}, 32'd0);
        check("t6_ready_zero", {31'd0, ex_ready}, 32'd0);
        check("t6_result_zero", mem_alu_result, 32'd0);
        tick();
        drive(1'b0, '0, '0, '0, '0, 1'b0);
        rst = 1'b0;
        tick();
        check("t6_no_bt_after", {31'd0, branch_taken}, 32'd0);
        check("t6_empty_after", {31'd0, mem_valid}, 32'd0);
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
